// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD conversion defaults and FSM state type.
package bcd_pkg;

    localparam int unsigned NUM_DIGITS_DEF = 11;
    localparam int unsigned BIN_WIDTH_DEF  = 37;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } bcd_state_t;

    // A packed BCD nibble is invalid above nine.
    function automatic logic nibble_invalid(input logic [3:0] nib);
        return nib > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// bcd_to_bin_seq_if: start/operand request and result bus of the BCD-to-binary converter.
interface bcd_to_bin_seq_if
    import bcd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int unsigned BIN_WIDTH  = BIN_WIDTH_DEF
);

    logic                    start;
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic                    busy;
    logic                    done;
    logic [BIN_WIDTH-1:0]    bin_out;
    logic                    err;

    modport master (
        output start, bcd_in,
        input  busy, done, bin_out, err
    );

    modport slave (
        input  start, bcd_in,
        output busy, done, bin_out, err
    );

endinterface

// File: rtl/bcd_to_bin_seq_digit_sub3.sv
// bcd_digit_sub3: reverse double-dabble correction for one BCD nibble.
module bcd_digit_sub3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib_c
);

    assign o_nib_c = (i_nib >= 4'd8) ? (i_nib - 4'd3) : i_nib;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential packed-BCD to binary converter (reverse double-dabble).
// Optional macro BCD2BIN_DIGIT_CHECK_EN rejects inputs containing a nibble above nine.
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int unsigned BIN_WIDTH  = BIN_WIDTH_DEF
) (
    input  logic            Clk,
    input  logic            Reset_n,
    bcd_to_bin_seq_if.slave bus
);

    localparam int unsigned BCD_W  = 4 * NUM_DIGITS;
    localparam int unsigned WORK_W = BCD_W + BIN_WIDTH;
    localparam int unsigned CNT_W  = $clog2(BIN_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_WIDTH - 1);

    bcd_state_t           r_state, w_state_nxt;
    logic [WORK_W-1:0]    r_work, w_work_nxt, w_work_shr, w_work_corr;
    logic [BCD_W-1:0]     w_bcd_corr;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic                 r_inv, w_inv_nxt, w_bcd_inv;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;
    logic                 r_err, w_err_nxt;
    logic [BIN_WIDTH-1:0] r_bin, w_bin_nxt;

    // One shift step: shift right, then correct every BCD nibble.
    assign w_work_shr = r_work >> 1;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit_sub3 u_sub3 (
            .i_nib   (w_work_shr[BIN_WIDTH + 4*g +: 4]),
            .o_nib_c (w_bcd_corr[4*g +: 4])
        );
    end

    assign w_work_corr = {w_bcd_corr, w_work_shr[BIN_WIDTH-1:0]};

`ifdef BCD2BIN_DIGIT_CHECK_EN
    always_comb begin
        w_bcd_inv = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (nibble_invalid(bus.bcd_in[4*i +: 4])) w_bcd_inv = 1'b1;
        end
    end
`else
    assign w_bcd_inv = 1'b0;
`endif

    // Outputs are registered from the current state, so they trail it by one edge.
    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_cnt_nxt   = r_cnt;
        w_inv_nxt   = r_inv;
        w_busy_nxt  = (r_state != ST_IDLE);
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;
        w_bin_nxt   = r_bin;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_work_nxt  = {bus.bcd_in, {BIN_WIDTH{1'b0}}};
                    w_cnt_nxt   = '0;
                    w_inv_nxt   = w_bcd_inv;
                    w_state_nxt = w_bcd_inv ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_work_nxt = w_work_corr;
                w_cnt_nxt  = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_LAST) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_done_nxt  = 1'b1;
                w_err_nxt   = r_inv;
                w_bin_nxt   = r_inv ? '0 : r_work[BIN_WIDTH-1:0];
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
            r_work  <= '0;
            r_cnt   <= '0;
            r_inv   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_bin   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
            r_cnt   <= w_cnt_nxt;
            r_inv   <= w_inv_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_bin   <= w_bin_nxt;
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.err     = r_err;
    assign bus.bin_out = r_bin;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: directed and round-trip checks of the BCD-to-binary converter.
// Honours BCD2BIN_DIGIT_CHECK_EN for the invalid-digit case.
module tb_bcd_to_bin_seq;

    localparam int unsigned ND = bcd_pkg::NUM_DIGITS_DEF;
    localparam int unsigned BW = bcd_pkg::BIN_WIDTH_DEF;

    logic Clk;
    logic Reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    bcd_to_bin_seq_if bus ();

    bcd_to_bin_seq u_dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Edges after the accepting edge until done is seen; -1 if it never comes.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge Clk); #1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
    endtask

    function automatic logic [4*ND-1:0] bin2bcd(input logic [63:0] n);
        logic [63:0]     t;
        logic [4*ND-1:0] r;
        t = n;
        r = '0;
        for (int i = 0; i < int'(ND); i++) begin
            r[4*i +: 4] = 4'(t % 64'd10);
            t = t / 64'd10;
        end
        return r;
    endfunction

    task automatic run_conv(input string tag, input logic [4*ND-1:0] bcd, input logic [63:0] exp_bin,
                            input int exp_lat, input logic exp_err, input bit chk_bin);
        int lat;
        bus.bcd_in = bcd;
        bus.start  = 1'b1;
        @(posedge Clk); #1;
        bus.start  = 1'b0;
        bus.bcd_in = ~bcd;
        wait_done(lat);
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_err"}, 64'(bus.err), 64'(exp_err));
        if (chk_bin) check_eq({tag, "_bin"}, 64'(bus.bin_out), exp_bin);
        @(posedge Clk); #1;
        check_eq({tag, "_pulse"}, 64'(bus.done), 64'd0);
        if (chk_bin) check_eq({tag, "_hold"}, 64'(bus.bin_out), exp_bin);
    endtask

    initial begin
        int          lat;
        int          n_done;
        int          done_at;
        logic [63:0] vals [6];

        Reset_n    = 1'b0;
        bus.start  = 1'b0;
        bus.bcd_in = '0;
        repeat (3) @(posedge Clk);
        #1;
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_done", 64'(bus.done), 64'd0);
        check_eq("rst_err",  64'(bus.err), 64'd0);
        check_eq("rst_bin",  64'(bus.bin_out), 64'd0);
        Reset_n = 1'b1;
        @(posedge Clk); #1;

        // Directed values, including nibbles at and around the >=8 correction threshold.
        run_conv("zero",   44'h0,           64'h0,          38, 1'b0, 1'b1);
        run_conv("b255",   44'h255,         64'hFF,         38, 1'b0, 1'b1);
        run_conv("all9",   44'h99999999999, 64'h174876E7FF, 38, 1'b0, 1'b1);
        run_conv("one",    44'h1,           64'h1,          38, 1'b0, 1'b1);
        run_conv("ten",    44'h10,          64'hA,          38, 1'b0, 1'b1);
        run_conv("eight",  44'h8,           64'h8,          38, 1'b0, 1'b1);
        run_conv("eighty", 44'h80,          64'h50,         38, 1'b0, 1'b1);
        run_conv("mixed",  44'h12345678901, 64'h2DFDC1C35,  38, 1'b0, 1'b1);

        // Second start mid-conversion must be ignored.
        bus.bcd_in = 44'h255;
        bus.start  = 1'b1;
        @(posedge Clk); #1;
        bus.start  = 1'b0;
        n_done  = 0;
        done_at = -1;
        for (int k = 1; k <= 45; k++) begin
            @(posedge Clk); #1;
            if (k == 10) begin
                bus.start  = 1'b1;
                bus.bcd_in = 44'h99999999999;
            end
            if (k == 11) bus.start = 1'b0;
            if (bus.done) begin
                n_done++;
                done_at = k;
                check_eq("ign_bin", 64'(bus.bin_out), 64'hFF);
            end
        end
        check_eq("ign_ndone", 64'(n_done), 64'd1);
        check_eq("ign_at",    64'(done_at), 64'd38);

        // Reset mid-conversion aborts it; start held during reset is ignored.
        bus.bcd_in = 44'h99999999999;
        bus.start  = 1'b1;
        @(posedge Clk); #1;
        bus.start  = 1'b0;
        repeat (20) @(posedge Clk);
        #1;
        Reset_n   = 1'b0;
        bus.start = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        check_eq("abort_busy", 64'(bus.busy), 64'd0);
        check_eq("abort_done", 64'(bus.done), 64'd0);
        check_eq("abort_err",  64'(bus.err), 64'd0);
        check_eq("abort_bin",  64'(bus.bin_out), 64'd0);
        Reset_n   = 1'b1;
        bus.start = 1'b0;
        n_done    = 0;
        for (int k = 1; k <= 45; k++) begin
            @(posedge Clk); #1;
            if (bus.done) n_done++;
        end
        check_eq("abort_nodone", 64'(n_done), 64'd0);
        check_eq("abort_idle",   64'(bus.busy), 64'd0);
        run_conv("post_rst", 44'h255, 64'hFF, 38, 1'b0, 1'b1);

`ifdef BCD2BIN_DIGIT_CHECK_EN
        run_conv("inv", 44'h1A3, 64'h0, 1, 1'b1, 1'b1);
`else
        run_conv("inv", 44'h1A3, 64'h0, 38, 1'b0, 1'b0);
`endif

        // Round trip with start held high: next operand presented right after each accept.
        foreach (vals[j]) vals[j] = {$urandom, $urandom} % 64'd100000000000;
        vals[0]    = 64'd99999999999;
        bus.bcd_in = bin2bcd(vals[0]);
        bus.start  = 1'b1;
        @(posedge Clk); #1;
        for (int j = 0; j < 6; j++) begin
            if (j < 5) bus.bcd_in = bin2bcd(vals[j+1]);
            wait_done(lat);
            check_eq("b2b_lat", 64'(lat), 64'd38);
            check_eq("b2b_bin", 64'(bus.bin_out), vals[j]);
            if (j == 5) bus.start = 1'b0;
            @(posedge Clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin_seq.md
BCD_TO_BIN_SEQ -- requirements
Module: bcd_to_bin_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset, named Clk and Reset_n.
REQ-002 Parameter NUM_DIGITS SHALL have default 11 and set the number of packed BCD digits.
REQ-003 Parameter BIN_WIDTH SHALL have default 37 and set the binary result width (ceil(log2(10^NUM_DIGITS))).
REQ-004 Clk  input  1  SHALL be the rising-edge clock for all state.
REQ-005 Reset_n  input  1  SHALL be the synchronous active-low reset.
REQ-006 start  input  1  SHALL request a conversion; it is sampled only in IDLE.
REQ-007 bcd_in  input  4*NUM_DIGITS  SHALL carry packed BCD with digit 0 in [3:0], sampled on the accepting edge.
REQ-008 busy  output  1  SHALL be high while a conversion is in progress (SHIFT or DONE).
REQ-009 done  output  1  SHALL be a one-cycle pulse marking bin_out/err valid.
REQ-010 bin_out  output  BIN_WIDTH  SHALL hold the binary result, stable from done until the next accepted start.
REQ-011 err  output  1  SHALL flag an invalid input digit (see Configuration), valid with done.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT, DONE; reset enters IDLE.
REQ-013 In IDLE with start=1, the block SHALL load {bcd_in, BIN_WIDTH'b0} into a work register, clear the counter, and enter SHIFT on that edge.
REQ-014 Each SHIFT cycle SHALL shift the work register right one bit, then subtract 3 from every BCD nibble whose value is >= 8 (reverse double-dabble).
REQ-015 The counter SHALL be $clog2(BIN_WIDTH+1) bits wide and SHALL enter DONE after exactly BIN_WIDTH shift cycles.
REQ-016 On entering DONE, bin_out SHALL load the low BIN_WIDTH bits of the work register; done and busy SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-017 Latency SHALL be BIN_WIDTH+1 cycles from the start-accepting edge to the edge that asserts done (38 cycles by default).
REQ-018 start asserted while busy=1 SHALL be ignored, not queued.
REQ-019 start held high continuously SHALL start a new conversion on the first IDLE cycle after done (back-to-back throughput BIN_WIDTH+2 cycles).
REQ-020 bcd_in changes after the accepting edge SHALL NOT affect the current result.

Reset
REQ-021 Reset_n=0 at a rising edge SHALL force IDLE, busy=0, done=0, err=0, bin_out=0, and clear the work register and counter, including mid-conversion (the conversion is aborted and no done is produced).
REQ-022 start coincident with Reset_n=0 SHALL be ignored.

Configuration
REQ-023 With BCD2BIN_DIGIT_CHECK_EN defined, an accepted bcd_in containing any nibble > 9 SHALL skip SHIFT, go directly to DONE on the next edge with err=1 and bin_out=0 (latency 1 cycle).
REQ-024 Without BCD2BIN_DIGIT_CHECK_EN, err SHALL be constant 0 and invalid digits SHALL run the normal algorithm with an unspecified but deterministic result.

Structure
REQ-025 Package bcd_pkg SHALL hold the NUM_DIGITS/BIN_WIDTH defaults and the FSM state typedef, shared with the existing binary-to-BCD shift register.
REQ-026 Per-nibble correction (>=8 then subtract 3) SHALL be a combinational sub-module bcd_digit_sub3, instantiated NUM_DIGITS times via generate.

Verification
REQ-027 Reset, then bcd_in=0, start -> done at cycle 38, bin_out=0, err=0.
REQ-028 bcd_in=0x255 (BCD 255), start -> bin_out=0xFF; bcd_in=0x99999999999 -> bin_out=37'h174876E7FF.
REQ-029 start pulsed again at cycle 10 of a conversion -> ignored; exactly one done pulse at cycle 38, result of the first input.
REQ-030 Reset_n low at cycle 20 of a conversion -> no done, all outputs 0; a new start completes correctly.
REQ-031 With BCD2BIN_DIGIT_CHECK_EN defined, bcd_in=0x1A3 -> done after 1 cycle, err=1, bin_out=0; without the macro, err stays 0.
REQ-032 Random valid BCD values, checked through the existing binary-to-BCD shift register as a round-trip, SHALL match with start held high back-to-back.
